rom_dl_router: RTL and testbench

- Generalised ROM download controller for MiST arcade cores.
- Takes the byte-wide data_io download stream and packs consecutive even/odd bytes into 16-bit words.
- Routes each word to one of NPORTS SDRAM write ports, selected by parametrised address regions, using a toggle req/ack handshake.
- Also produces the stretched core reset and the sticky rom_loaded flag, replacing the per-core ad-hoc download and reset logic.

---
 rtl/rom_dl_router.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rom_dl_router.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_router.sv
// rom_dl_router: packs the data_io download byte stream into 16-bit words,
// routes each word to an address-mapped SDRAM write port over a toggle
// req/ack handshake, and generates the stretched core reset and rom_loaded.
module rom_dl_router #(
  parameter int                   NPORTS = 2,
  parameter int                   AW     = 25,
  parameter logic [NPORTS*AW-1:0] BASES  = {25'h10000, 25'h0},
  parameter logic [NPORTS*AW-1:0] SIZES  = {25'h0C000, 25'h10000},
  parameter int                   RST_W  = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic              ioctl_wr,
  input  logic [AW-1:0]     ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ext_reset,
  output logic [NPORTS-1:0] port_req,
  input  logic [NPORTS-1:0] port_ack,
  output logic [AW-2:0]     port_a,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  output logic              port_we,
  output logic              rom_loaded,
  output logic              core_reset,
  output logic              overrun
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, downl_q;
  logic              stb_q, stb_d, fall_q, fall_d;
  logic [AW-1:0]     addr_q;
  logic [7:0]        dout_q;
  logic              pend_v_q, pend_v_d;
  logic [7:0]        pend_b_q, pend_b_d;
  logic [AW-1:0]     pend_local_q, pend_local_d;
  logic [PW-1:0]     pend_port_q, pend_port_d;
  logic              fl_q, fl_d, ended_q, ended_d;
  logic [PW-1:0]     iss_port_q, iss_port_d;
  logic [NPORTS-1:0] req_q, req_d;
  logic [AW-2:0]     a_q, a_d;
  logic [1:0]        ds_q, ds_d;
  logic [15:0]       d_q, d_d;
  logic              we_q, we_d, loaded_q, loaded_d, ovr_q, ovr_d;
  logic [RST_W-1:0]  cnt_q, cnt_d;
  logic              crst_q, crst_d;

  logic              hit_s, pair_s, flush_now_s;
  logic [PW-1:0]     hit_port_s;
  logic [AW-1:0]     local_s, base_s, top_s;
  logic              iss_s;
  logic [PW-1:0]     iss_sel_s;
  logic [AW-2:0]     iss_a_s;
  logic [1:0]        iss_ds_s;
  logic [15:0]       iss_d_s;

  // Edge detection: strobe rising edge and download falling edge.
  always_comb begin
    stb_d  = ioctl_wr & ~wr_q;
    fall_d = ~ioctl_downl & downl_q;
  end

  // Region decode: scan high to low so the lowest matching region wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_port_s = '0;
    local_s    = '0;
    base_s     = '0;
    top_s      = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      base_s = BASES[k*AW +: AW];
      top_s  = base_s + SIZES[k*AW +: AW];
      if ((addr_q >= base_s) && (addr_q < top_s)) begin
        hit_s      = 1'b1;
        hit_port_s = PW'(k);
        local_s    = addr_q - base_s;
      end else begin
        // this region does not claim the address
      end
    end
    pair_s = pend_v_q && (pend_port_q == hit_port_s) &&
             (pend_local_q == (local_s - AW'(1)));
  end

  // Packing FSM, handshake, rom_loaded and reset stretcher next-state logic.
  always_comb begin
    state_d      = state_q;
    pend_v_d     = pend_v_q;
    pend_b_d     = pend_b_q;
    pend_local_d = pend_local_q;
    pend_port_d  = pend_port_q;
    flush_now_s  = fl_q | fall_q;
    fl_d         = fl_q | fall_q;
    ended_d      = ended_q;
    ovr_d        = ovr_q;
    req_d        = req_q;
    iss_port_d   = iss_port_q;
    a_d          = a_q;
    ds_d         = ds_q;
    d_d          = d_q;
    iss_s        = 1'b0;
    iss_sel_s    = '0;
    iss_a_s      = '0;
    iss_ds_s     = 2'b00;
    iss_d_s      = 16'h0000;
    case (state_q)
      IDLE: begin
        if (stb_q && hit_s && !addr_q[0]) begin
          // even byte: flush any older lone byte, then hold the new one
          if (pend_v_q) begin
            iss_s     = 1'b1;
            iss_sel_s = pend_port_q;
            iss_a_s   = pend_local_q[AW-1:1];
            iss_ds_s  = 2'b01;
            iss_d_s   = {pend_b_q, pend_b_q};
          end else begin
            iss_s = 1'b0;
          end
          pend_v_d     = 1'b1;
          pend_b_d     = dout_q;
          pend_local_d = local_s;
          pend_port_d  = hit_port_s;
        end else if (stb_q && hit_s) begin
          // odd byte: full word if it completes the pending byte, else hi-only
          iss_s     = 1'b1;
          iss_sel_s = hit_port_s;
          iss_a_s   = local_s[AW-1:1];
          if (pair_s) begin
            iss_ds_s = 2'b11;
            iss_d_s  = {dout_q, pend_b_q};
            pend_v_d = 1'b0;
          end else begin
            iss_ds_s = 2'b10;
            iss_d_s  = {dout_q, dout_q};
          end
        end else if (stb_q) begin
          // unmapped byte is dropped; a queued flush waits for the next IDLE
          iss_s = 1'b0;
        end else if (flush_now_s) begin
          fl_d    = 1'b0;
          ended_d = 1'b1;
          if (pend_v_q) begin
            iss_s     = 1'b1;
            iss_sel_s = pend_port_q;
            iss_a_s   = pend_local_q[AW-1:1];
            iss_ds_s  = 2'b01;
            iss_d_s   = {pend_b_q, pend_b_q};
            pend_v_d  = 1'b0;
          end else begin
            iss_s = 1'b0;
          end
        end else begin
          iss_s = 1'b0;
        end
        if (iss_s) begin
          state_d    = ISSUE;
          iss_port_d = iss_sel_s;
          a_d        = iss_a_s;
          ds_d       = iss_ds_s;
          d_d        = iss_d_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        req_d[iss_port_q] = ~req_q[iss_port_q];
        state_d           = WAIT;
        ovr_d             = ovr_q | stb_q;
      end
      WAIT: begin
        if (port_ack[iss_port_q] == req_q[iss_port_q]) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
        ovr_d = ovr_q | stb_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    we_d     = ioctl_downl | (state_d != IDLE);
    loaded_d = loaded_q | (~downl_q & ended_q & (state_q == IDLE) & ~pend_v_q);

    if (ext_reset | downl_q | ~loaded_q) begin
      cnt_d = '1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - RST_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    crst_d = (cnt_q != '0);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      downl_q      <= 1'b0;
      stb_q        <= 1'b0;
      fall_q       <= 1'b0;
      addr_q       <= '0;
      dout_q       <= 8'h00;
      pend_v_q     <= 1'b0;
      pend_b_q     <= 8'h00;
      pend_local_q <= '0;
      pend_port_q  <= '0;
      fl_q         <= 1'b0;
      ended_q      <= 1'b0;
      iss_port_q   <= '0;
      req_q        <= '0;
      a_q          <= '0;
      ds_q         <= 2'b00;
      d_q          <= 16'h0000;
      we_q         <= 1'b0;
      loaded_q     <= 1'b0;
      ovr_q        <= 1'b0;
      cnt_q        <= '1;
      crst_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_q         <= ioctl_wr;
      downl_q      <= ioctl_downl;
      stb_q        <= stb_d;
      fall_q       <= fall_d;
      addr_q       <= ioctl_addr;
      dout_q       <= ioctl_dout;
      pend_v_q     <= pend_v_d;
      pend_b_q     <= pend_b_d;
      pend_local_q <= pend_local_d;
      pend_port_q  <= pend_port_d;
      fl_q         <= fl_d;
      ended_q      <= ended_d;
      iss_port_q   <= iss_port_d;
      req_q        <= req_d;
      a_q          <= a_d;
      ds_q         <= ds_d;
      d_q          <= d_d;
      we_q         <= we_d;
      loaded_q     <= loaded_d;
      ovr_q        <= ovr_d;
      cnt_q        <= cnt_d;
      crst_q       <= crst_d;
    end
  end

  assign port_req   = req_q;
  assign port_a     = a_q;
  assign port_ds    = ds_q;
  assign port_d     = d_q;
  assign port_we    = we_q;
  assign rom_loaded = loaded_q;
  assign core_reset = crst_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: directed stimulus with a write scoreboard; expected port
// writes are queued when bytes are sent and checked when a req toggles.
module tb_rom_dl_router;

  localparam int NP = 2;
  localparam int AW = 25;
  localparam int RW = 4;

  typedef struct packed {
    logic [31:0]   port;
    logic [AW-2:0] a;
    logic [1:0]    ds;
    logic [15:0]   d;
  } wr_t;

  logic          clk_sys     = 1'b0;
  logic          reset_n     = 1'b0;
  logic          ioctl_downl = 1'b0;
  logic          ioctl_wr    = 1'b0;
  logic [AW-1:0] ioctl_addr  = '0;
  logic [7:0]    ioctl_dout  = 8'h00;
  logic          ext_reset   = 1'b0;
  logic [NP-1:0] port_req, port_ack;
  logic [AW-2:0] port_a;
  logic [1:0]    port_ds;
  logic [15:0]   port_d;
  logic          port_we, rom_loaded, core_reset, overrun;

  logic          ack_en = 1'b1;
  logic [NP-1:0] ack_r;
  logic [1:0]    dly [NP];
  logic [NP-1:0] req_prev = '0;
  wr_t           exp_q [$];

  int checks   = 0;
  int errors   = 0;
  int toggles  = 0;
  int cyc      = 0;
  int last_tog = 0;
  int wr_cyc   = 0;
  int n        = 0;

  always #5 clk_sys = ~clk_sys;

  rom_dl_router #(
    .NPORTS(NP), .AW(AW),
    .BASES({25'h10000, 25'h0}), .SIZES({25'h0C000, 25'h10000}),
    .RST_W(RW)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ext_reset(ext_reset),
    .port_req(port_req), .port_ack(port_ack),
    .port_a(port_a), .port_ds(port_ds), .port_d(port_d), .port_we(port_we),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overrun(overrun)
  );

  assign port_ack = ack_r;

  // SDRAM-side model: echo each req toggle back as ack after a short delay.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_r <= '0;
      for (int k = 0; k < NP; k++) dly[k] <= 2'd0;
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (ack_en && (port_req[k] != ack_r[k])) begin
          if (dly[k] == 2'd2) begin
            ack_r[k] <= port_req[k];
            dly[k]   <= 2'd0;
          end else begin
            dly[k] <= dly[k] + 2'd1;
          end
        end else begin
          dly[k] <= 2'd0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [AW-2:0] a, input logic [1:0] ds, input logic [15:0] d);
    wr_t e;
    e.port = 32'(p);
    e.a    = a;
    e.ds   = ds;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    wr_t e;
    @(posedge clk_sys);
    #1;
    cyc++;
    for (int k = 0; k < NP; k++) begin
      if (port_req[k] !== req_prev[k]) begin
        toggles++;
        last_tog = cyc;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed toggle on port %0d, expected none", k);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_port", 32'(k), e.port);
          chk("wr_a", 32'(port_a), 32'(e.a));
          chk("wr_ds", 32'(port_ds), 32'(e.ds));
          chk("wr_d", 32'(port_d), 32'(e.d));
        end
      end
    end
    req_prev = port_req;
  endtask

  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] b);
    ioctl_addr = a;
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    repeat (11) tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(port_req), 32'd0);
    chk({tag, "_a"}, 32'(port_a), 32'd0);
    chk({tag, "_ds"}, 32'(port_ds), 32'd0);
    chk({tag, "_d"}, 32'(port_d), 32'd0);
    chk({tag, "_we"}, 32'(port_we), 32'd0);
    chk({tag, "_loaded"}, 32'(rom_loaded), 32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    // power-on reset
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset("por");
    reset_n = 1'b1;
    tick();
    tick();

    // packing: two bytes into one full word on port 0
    ioctl_downl = 1'b1;
    tick();
    tick();
    chk("we_during_dl", 32'(port_we), 32'd1);
    send_byte(25'h00000, 8'h12);
    chk("even_byte_no_write", 32'(toggles), 32'd0);
    push(0, 24'h000000, 2'b11, 16'h3412);
    wr_cyc = cyc + 1;
    send_byte(25'h00001, 8'h34);
    chk("pack_latency", 32'(last_tog - wr_cyc), 32'd2);
    chk("pack_toggles", 32'(toggles), 32'd1);
    chk("pack_no_overrun", 32'(overrun), 32'd0);

    // region routing to port 1
    send_byte(25'h10004, 8'hAB);
    push(1, 24'h000002, 2'b11, 16'hCDAB);
    send_byte(25'h10005, 8'hCD);
    chk("region_toggles", 32'(toggles), 32'd2);

    // lone bytes: hi-only write, then flush at download end
    send_byte(25'h00006, 8'h55);
    push(0, 24'h000004, 2'b10, 16'h6666);
    send_byte(25'h00009, 8'h66);
    chk("lone_toggles", 32'(toggles), 32'd3);
    chk("loaded_during_dl", 32'(rom_loaded), 32'd0);
    push(0, 24'h000003, 2'b01, 16'h5555);
    ioctl_downl = 1'b0;
    repeat (12) tick();
    chk("flush_toggles", 32'(toggles), 32'd4);
    chk("loaded_after_flush", 32'(rom_loaded), 32'd1);
    chk("we_after_dl", 32'(port_we), 32'd0);
    chk("queue_empty_dl1", 32'(exp_q.size()), 32'd0);

    // reset stretcher
    n = 0;
    while (core_reset && (n < 60)) begin
      tick();
      n++;
    end
    chk("stretch_release", 32'(core_reset), 32'd0);
    ext_reset = 1'b1;
    tick();
    ext_reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("stretch_hold", 32'(core_reset), 32'd1);
    end
    tick();
    chk("stretch_fall", 32'(core_reset), 32'd0);
    repeat (4) begin
      tick();
      chk("stretch_stay", 32'(core_reset), 32'd0);
    end

    // overrun: ack held static while a second word pair arrives
    ioctl_downl = 1'b1;
    ack_en      = 1'b0;
    tick();
    tick();
    send_byte(25'h00020, 8'h11);
    push(0, 24'h000010, 2'b11, 16'h2211);
    send_byte(25'h00021, 8'h22);
    chk("ovr_first_toggles", 32'(toggles), 32'd5);
    chk("ovr_clear_before", 32'(overrun), 32'd0);
    send_byte(25'h00022, 8'h77);
    chk("overrun_set", 32'(overrun), 32'd1);
    send_byte(25'h00023, 8'h88);
    ack_en = 1'b1;
    repeat (12) tick();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("dropped_no_write", 32'(toggles), 32'd5);
    chk("queue_empty_ovr", 32'(exp_q.size()), 32'd0);

    // reset asserted while a write waits for its ack
    ack_en = 1'b0;
    send_byte(25'h00030, 8'h01);
    push(0, 24'h000018, 2'b11, 16'h0201);
    send_byte(25'h00031, 8'h02);
    chk("wait_toggles", 32'(toggles), 32'd6);
    chk("we_in_wait", 32'(port_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset("mid_wait");
    req_prev    = port_req;
    ioctl_downl = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    ack_en  = 1'b1;
    repeat (10) tick();
    chk("post_rst_toggles", 32'(toggles), 32'd6);
    chk("post_rst_loaded", 32'(rom_loaded), 32'd0);
    chk("post_rst_core_reset", 32'(core_reset), 32'd1);
    chk("post_rst_overrun", 32'(overrun), 32'd0);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
